// File: rtl/input_autorepeat_pkg.sv
// Shared types and default timing for the button auto-repeat logic.
// The game FSM and the testbenches import the defaults from here as well.
package input_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_L    = 2'b01,
        DIR_R    = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        AR_IDLE   = 2'b00,
        AR_DELAY  = 2'b01,
        AR_REPEAT = 2'b10
    } ar_state_t;

    // 170 ms delayed auto-shift and 50 ms repeat rate at 25 MHz
    localparam int DAS_CYCLES_DEF = 4_250_000;
    localparam int ARR_CYCLES_DEF = 1_250_000;
    localparam int CNT_W_DEF      = 23;

endpackage

// File: rtl/input_autorepeat_timer.sv
// Interval counter for the auto-repeat FSM. Counts while run is high and
// pulses expire on the cycle the count reaches the selected limit minus one,
// wrapping itself to zero so the next interval starts immediately.
module autorepeat_timer #(
    parameter int CNT_W      = 23,
    parameter int DAS_CYCLES = 4_250_000,
    parameter int ARR_CYCLES = 1_250_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    input  logic sel_das,
    output logic expire
);

    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYCLES - 1);

    // A limit below two would make the second strobe collide with the first.
    if (DAS_CYCLES < 2) begin : g_das_check
        $error("autorepeat_timer: DAS_CYCLES must be >= 2");
    end
    if (ARR_CYCLES < 2) begin : g_arr_check
        $error("autorepeat_timer: ARR_CYCLES must be >= 2");
    end

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] limit_s;

    // Select the active interval and flag when the count reaches its end.
    always_comb begin
        limit_s = ARR_LAST;
        expire  = 1'b0;
        if (sel_das) begin
            limit_s = DAS_LAST;
        end else begin
            limit_s = ARR_LAST;
        end
        if (run && (cnt_r == limit_s)) begin
            expire = 1'b1;
        end else begin
            expire = 1'b0;
        end
    end

    // Counter: clear has priority, expiry wraps to zero, otherwise count while running.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (expire) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (run) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/input_autorepeat.sv
// Turns debounced left/right button levels into one-cycle move strobes with
// delayed auto-shift and auto-repeat. The most recently pressed side owns the
// repeat; on a simultaneous press from idle, left wins.
module input_autorepeat
    import input_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int DAS_CYCLES = DAS_CYCLES_DEF,
    parameter int ARR_CYCLES = ARR_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_l,
    input  logic       btn_r,
    output logic       move_l,
    output logic       move_r,
    output logic [1:0] active_dir
);

    ar_state_t state_r;
    dir_t      dir_r;
    logic      prev_l_r;
    logic      prev_r_r;
    logic      move_l_r;
    logic      move_r_r;
    dir_t      active_dir_r;

    logic      rise_l_s;
    logic      rise_r_s;
    logic      own_held_s;
    logic      other_held_s;
    logic      other_rise_s;
    dir_t      other_dir_s;
    logic      clear_s;
    logic      run_s;
    logic      sel_das_s;
    logic      expire_s;

    // Edge detection and owner/other view of the buttons for the FSM.
    always_comb begin
        rise_l_s     = btn_l & ~prev_l_r;
        rise_r_s     = btn_r & ~prev_r_r;
        own_held_s   = 1'b0;
        other_held_s = 1'b0;
        other_rise_s = 1'b0;
        other_dir_s  = DIR_NONE;
        case (dir_r)
            DIR_L: begin
                own_held_s   = btn_l;
                other_held_s = btn_r;
                other_rise_s = rise_r_s;
                other_dir_s  = DIR_R;
            end
            DIR_R: begin
                own_held_s   = btn_r;
                other_held_s = btn_l;
                other_rise_s = rise_l_s;
                other_dir_s  = DIR_L;
            end
            default: begin
                own_held_s   = 1'b0;
                other_held_s = 1'b0;
                other_rise_s = 1'b0;
                other_dir_s  = DIR_NONE;
            end
        endcase
    end

    // Timer control: restart on any new press, handover or release; hold at zero when idle.
    always_comb begin
        run_s     = (state_r != AR_IDLE);
        sel_das_s = (state_r == AR_DELAY);
        if (state_r == AR_IDLE) begin
            clear_s = 1'b1;
        end else if (!own_held_s || other_rise_s) begin
            clear_s = 1'b1;
        end else begin
            clear_s = 1'b0;
        end
    end

    autorepeat_timer #(
        .CNT_W      (CNT_W),
        .DAS_CYCLES (DAS_CYCLES),
        .ARR_CYCLES (ARR_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear_s),
        .run     (run_s),
        .sel_das (sel_das_s),
        .expire  (expire_s)
    );

    // Arbitration FSM with registered strobes and direction indicator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= AR_IDLE;
            dir_r        <= DIR_NONE;
            prev_l_r     <= 1'b0;
            prev_r_r     <= 1'b0;
            move_l_r     <= 1'b0;
            move_r_r     <= 1'b0;
            active_dir_r <= DIR_NONE;
        end else begin
            prev_l_r <= btn_l;
            prev_r_r <= btn_r;
            move_l_r <= 1'b0;
            move_r_r <= 1'b0;
            case (state_r)
                AR_IDLE: begin
                    if (rise_l_s) begin
                        state_r      <= AR_DELAY;
                        dir_r        <= DIR_L;
                        active_dir_r <= DIR_L;
                        move_l_r     <= 1'b1;
                    end else if (rise_r_s) begin
                        state_r      <= AR_DELAY;
                        dir_r        <= DIR_R;
                        active_dir_r <= DIR_R;
                        move_r_r     <= 1'b1;
                    end else begin
                        dir_r        <= DIR_NONE;
                        active_dir_r <= DIR_NONE;
                    end
                end
                AR_DELAY, AR_REPEAT: begin
                    if ((!own_held_s && other_held_s) || (own_held_s && other_rise_s)) begin
                        // Other side takes over as a fresh press.
                        state_r      <= AR_DELAY;
                        dir_r        <= other_dir_s;
                        active_dir_r <= other_dir_s;
                        move_l_r     <= (other_dir_s == DIR_L);
                        move_r_r     <= (other_dir_s == DIR_R);
                    end else if (!own_held_s) begin
                        // Release beats a coincident expiry: no strobe.
                        state_r      <= AR_IDLE;
                        dir_r        <= DIR_NONE;
                        active_dir_r <= DIR_NONE;
                    end else if (expire_s) begin
                        state_r  <= AR_REPEAT;
                        move_l_r <= (dir_r == DIR_L);
                        move_r_r <= (dir_r == DIR_R);
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r      <= AR_IDLE;
                    dir_r        <= DIR_NONE;
                    active_dir_r <= DIR_NONE;
                end
            endcase
        end
    end

    assign move_l     = move_l_r;
    assign move_r     = move_r_r;
    assign active_dir = active_dir_r;

endmodule

// File: tb/tb_input_autorepeat.sv
// Self-checking bench for input_autorepeat with DAS=8, ARR=3. Directed
// scenarios followed by random button activity, all compared per cycle against
// a timestamp-based reference model.
module tb_input_autorepeat;

    localparam int DAS = 8;
    localparam int ARR = 3;

    logic       clk;
    logic       rst_n;
    logic       btn_l;
    logic       btn_r;
    logic       move_l;
    logic       move_r;
    logic [1:0] active_dir;

    int n_checks;
    int n_errors;
    int cyc;

    // Reference model state: owner (0 none, 1 left, 2 right), time of the
    // last strobe, and how many strobes the current press has produced.
    int   m_owner;
    int   m_last;
    int   m_count;
    logic m_pl;
    logic m_pr;
    logic exp_l;
    logic exp_r;
    logic [1:0] exp_dir;

    input_autorepeat #(
        .CNT_W      (4),
        .DAS_CYCLES (DAS),
        .ARR_CYCLES (ARR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_l      (btn_l),
        .btn_r      (btn_r),
        .move_l     (move_l),
        .move_r     (move_r),
        .active_dir (active_dir)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", tag, cyc, got, want);
        end
    endtask

    // Model: a fresh press strobes now; a held press strobes again DAS cycles
    // after its first strobe and every ARR cycles after that.
    task automatic model_press(input int side, input int when);
        m_owner = side;
        m_last  = when;
        m_count = 1;
        exp_l   = (side == 1);
        exp_r   = (side == 2);
    endtask

    // Advance the model over the clock edge ending cycle cyc; outputs are for cyc+1.
    task automatic model_step(input logic bl, input logic br, input logic rn);
        logic rise_l;
        logic rise_r;
        logic own_held;
        logic oth_held;
        logic oth_rise;
        int   other;
        int   gap;
        exp_l = 1'b0;
        exp_r = 1'b0;
        if (!rn) begin
            m_owner = 0;
            m_pl    = 1'b0;
            m_pr    = 1'b0;
        end else begin
            rise_l = bl && !m_pl;
            rise_r = br && !m_pr;
            m_pl   = bl;
            m_pr   = br;
            if (m_owner == 0) begin
                if (rise_l)      model_press(1, cyc + 1);
                else if (rise_r) model_press(2, cyc + 1);
            end else begin
                other    = 3 - m_owner;
                own_held = (m_owner == 1) ? bl : br;
                oth_held = (other == 1) ? bl : br;
                oth_rise = (other == 1) ? rise_l : rise_r;
                gap      = (m_count == 1) ? DAS : ARR;
                if (!own_held) begin
                    if (oth_held) model_press(other, cyc + 1);
                    else          m_owner = 0;
                end else if (oth_rise) begin
                    model_press(other, cyc + 1);
                end else if ((cyc + 1) - m_last == gap) begin
                    m_last  = cyc + 1;
                    m_count = m_count + 1;
                    exp_l   = (m_owner == 1);
                    exp_r   = (m_owner == 2);
                end
            end
        end
        exp_dir = 2'(m_owner);
    endtask

    // One clock cycle: drive inputs, step model at the edge, check 1 ns later.
    task automatic step(input logic bl, input logic br, input logic rn);
        btn_l = bl;
        btn_r = br;
        rst_n = rn;
        @(posedge clk);
        model_step(bl, br, rn);
        cyc++;
        #1;
        check("move_l", {1'b0, move_l}, {1'b0, exp_l});
        check("move_r", {1'b0, move_r}, {1'b0, exp_r});
        check("active_dir", active_dir, exp_dir);
        check("exclusive", {1'b0, move_l & move_r}, 2'b00);
    endtask

    task automatic hold(input logic bl, input logic br, input int n);
        for (int i = 0; i < n; i++) step(bl, br, 1'b1);
    endtask

    int strobes_r;

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        m_owner  = 0;
        m_last   = 0;
        m_count  = 0;
        m_pl     = 1'b0;
        m_pr     = 1'b0;
        btn_l    = 1'b0;
        btn_r    = 1'b0;
        rst_n    = 1'b0;
        #2;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        hold(1'b0, 1'b0, 7);

        // Tap: left for 4 cycles
        hold(1'b1, 1'b0, 4);
        hold(1'b0, 1'b0, 6);

        // Long right hold, counting strobes independently of the model
        strobes_r = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (move_r) strobes_r++;
        end
        // 30 sampled cycles after the press edge: strobes at +1, +9, +12 ... +30
        check("hold_count", 2'(strobes_r > 3 ? 3 : strobes_r), 2'd3);
        hold(1'b0, 1'b0, 5);

        // Left held, right pressed over it, right released with left held
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 15);
        hold(1'b1, 1'b0, 15);
        hold(1'b0, 1'b0, 5);

        // Simultaneous press: left wins, right takes over on left release
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 12);
        hold(1'b0, 1'b0, 5);

        // Release exactly on a repeat expiry
        hold(1'b1, 1'b0, 11);
        hold(1'b0, 1'b0, 5);

        // Release of owner plus rise of other on the same cycle
        hold(1'b1, 1'b0, 6);
        hold(1'b0, 1'b1, 6);
        hold(1'b0, 1'b0, 4);

        // Reset in the middle of a hold, button kept down
        hold(1'b1, 1'b0, 5);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        hold(1'b1, 1'b0, 15);
        hold(1'b0, 1'b0, 5);

        // Random button activity with occasional resets
        begin
            logic bl;
            logic br;
            logic rn;
            bl = 1'b0;
            br = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(7, 0) == 0) bl = ~bl;
                if ($urandom_range(7, 0) == 0) br = ~br;
                rn = ($urandom_range(199, 0) != 0);
                step(bl, br, rn);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
